// File: rtl/axi4_slave_wr_engine_if.sv
// AXI4 write-channel bundle (AW/W/B) plus the per-beat memory write port driven by the engine.
interface axi4_slave_wr_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                      AWVALID;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic [7:0]                AWLEN;
  logic [2:0]                AWSIZE;
  logic [1:0]                AWBURST;
  logic [ID_WIDTH-1:0]       AWID;
  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WLAST;
  logic                      BVALID;
  logic                      BREADY;
  logic [ID_WIDTH-1:0]       BID;
  logic [1:0]                BRESP;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_wstrb;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    output WVALID, WDATA, WSTRB, WLAST, BREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP,
    input  mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    input  WVALID, WDATA, WSTRB, WLAST, BREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP,
    output mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/axi4_slave_wr_engine.sv
// AXI4 slave write engine: one burst at a time, FIXED/INCR/WRAP decoded into per-beat memory writes.
// Optional macro AXI4_SLV_WR_WLAST_CHK_EN flags misplaced WLAST as SLVERR.
module axi4_slave_wr_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input logic                  ACLK,
  input logic                  ARESET,
  axi4_slave_wr_engine_if.slave bus
);
  localparam int MAX_SIZE = $clog2(DATA_WIDTH/8);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [7:0]            cnt;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [ID_WIDTH-1:0]   id;
  logic                  err;
  logic                  beat;
  logic                  err_now;

  function automatic logic aw_error(input logic [2:0] s, input logic [1:0] b, input logic [7:0] l);
    logic bad_wrap;
    bad_wrap = (b == 2'b10) && !(l inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (int'(s) > MAX_SIZE) || (b == 2'b11) || bad_wrap;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] l,
                                                      input logic [2:0] s,
                                                      input logic [1:0] b);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    incr = ADDR_WIDTH'(1) << s;
    mask = (ADDR_WIDTH'({1'b0, l} + 9'd1) << s) - ADDR_WIDTH'(1);
    case (b)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + incr) & mask);
      default: return a + incr;
    endcase
  endfunction

  assign beat          = bus.WVALID & bus.WREADY;
  // Write strobe is combinational so each accepted beat lands in memory the same cycle.
  assign bus.mem_we    = beat & ~err;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = bus.WDATA;
  assign bus.mem_wstrb = bus.WSTRB;
  assign bus.BID       = id;

`ifdef AXI4_SLV_WR_WLAST_CHK_EN
  assign err_now = err | (bus.WLAST != (cnt == len));
`else
  logic wlast_unused;
  assign wlast_unused = bus.WLAST;
  assign err_now      = err;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= 2'b00;
      id          <= '0;
      addr        <= '0;
      len         <= '0;
      cnt         <= '0;
      size        <= '0;
      burst       <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.AWVALID && bus.AWREADY) begin
            addr        <= bus.AWADDR;
            len         <= bus.AWLEN;
            size        <= bus.AWSIZE;
            burst       <= bus.AWBURST;
            id          <= bus.AWID;
            cnt         <= '0;
            err         <= aw_error(bus.AWSIZE, bus.AWBURST, bus.AWLEN);
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b1;
            state       <= DATA;
          end else begin
            bus.AWREADY <= 1'b1;
          end
        end
        DATA: begin
          if (beat) begin
            addr <= next_addr(addr, len, size, burst);
            cnt  <= cnt + 8'd1;
            err  <= err_now;
            // Beat count, not WLAST, decides where the burst ends.
            if (cnt == len) begin
              bus.WREADY <= 1'b0;
              bus.BVALID <= 1'b1;
              bus.BRESP  <= err_now ? 2'b10 : 2'b00;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.BREADY) begin
            bus.BVALID  <= 1'b0;
            bus.AWREADY <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_slave_wr_engine.sv
// Randomised and directed bench for axi4_slave_wr_engine against a burst-level reference model.
module tb_axi4_slave_wr_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi4_slave_wr_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();
  axi4_slave_wr_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic give_up(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s at %0t", name, $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Reference model state
  int             ph;
  bit             aw_exp, w_exp, b_exp, t_err, b_err, exp_we;
  logic [31:0]    t_start;
  int             t_len, t_size, t_beat;
  logic [1:0]     t_burst;
  logic [3:0]     t_id;
  logic [31:0]    wr_log[$];
  logic [5:0]     b_log[$];

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len, input int size,
                                            input logic [1:0] burst, input int i);
    longint s, incr, total, base;
    s     = longint'(start);
    incr  = longint'(1) << size;
    total = longint'(len + 1) * incr;
    case (burst)
      2'b00: return start;
      2'b10: begin
        base = s - (s % total);
        return 32'(base + ((s - base + longint'(i) * incr) % total));
      end
      default: return 32'(s + longint'(i) * incr);
    endcase
  endfunction

  initial begin
    ph = 0; aw_exp = 0; w_exp = 0; b_exp = 0; t_err = 0; b_err = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        chk("rst_awready", bus.AWREADY, 0);
        chk("rst_wready", bus.WREADY, 0);
        chk("rst_bvalid", bus.BVALID, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_bid", bus.BID, 0);
        chk("rst_bresp", bus.BRESP, 0);
        ph = 0; aw_exp = 0; w_exp = 0; b_exp = 0;
      end else begin
        chk("awready", bus.AWREADY, aw_exp);
        chk("wready", bus.WREADY, w_exp);
        chk("bvalid", bus.BVALID, b_exp);
        if (b_exp) begin
          chk("bid", bus.BID, t_id);
          chk("bresp", bus.BRESP, b_err ? 2'b10 : 2'b00);
        end
        exp_we = bus.WVALID && w_exp && !t_err;
        chk("mem_we", bus.mem_we, exp_we);
        if (exp_we) begin
          chk("mem_addr", bus.mem_addr, beat_addr(t_start, t_len, t_size, t_burst, t_beat));
          chk("mem_wdata", bus.mem_wdata, bus.WDATA);
          chk("mem_wstrb", bus.mem_wstrb, bus.WSTRB);
          wr_log.push_back(bus.mem_addr);
        end
        case (ph)
          0: begin
            if (bus.AWVALID && aw_exp) begin
              t_start = bus.AWADDR; t_len = int'(bus.AWLEN); t_size = int'(bus.AWSIZE);
              t_burst = bus.AWBURST; t_id = bus.AWID; t_beat = 0;
              t_err = (t_size > 2) || (t_burst == 2'b11) ||
                      (t_burst == 2'b10 && !(t_len inside {1, 3, 7, 15}));
              ph = 1; aw_exp = 0; w_exp = 1;
            end else begin
              aw_exp = 1;
            end
          end
          1: begin
            if (bus.WVALID) begin
`ifdef AXI4_SLV_WR_WLAST_CHK_EN
              if (bus.WLAST != (t_beat == t_len)) t_err = 1;
`endif
              if (t_beat == t_len) begin
                ph = 2; w_exp = 0; b_exp = 1; b_err = t_err;
              end
              t_beat++;
            end
          end
          default: begin
            if (bus.BREADY) begin
              b_log.push_back({t_id, b_err ? 2'b10 : 2'b00});
              ph = 0; b_exp = 0; aw_exp = 1;
            end
          end
        endcase
      end
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [1:0] b, input logic [3:0] id);
    bus.AWVALID = 1'b1; bus.AWADDR = a; bus.AWLEN = l; bus.AWSIZE = s;
    bus.AWBURST = b; bus.AWID = id;
  endtask

  task automatic wait_aw();
    int k = 0;
    do begin
      @(negedge ACLK);
      k++;
      if (k > 100) give_up("aw");
    end while (!bus.AWREADY);
    tick();
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_beats(input int n, input int wlast_at, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int k;
      repeat ($urandom_range(0, gap_max)) tick();
      bus.WVALID = 1'b1; bus.WDATA = $urandom; bus.WSTRB = 4'($urandom);
      bus.WLAST = (i == wlast_at);
      k = 0;
      do begin
        @(negedge ACLK);
        k++;
        if (k > 100) give_up("w");
      end while (!bus.WREADY);
      tick();
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    end
  endtask

  task automatic get_b(input int hold);
    int k = 0;
    bus.BREADY = 1'b0;
    repeat (hold) tick();
    bus.BREADY = 1'b1;
    do begin
      @(negedge ACLK);
      k++;
      if (k > 100) give_up("b");
    end while (!bus.BVALID);
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] b, input logic [3:0] id, input int wlast_at, input int gap);
    set_aw(a, l, s, b, id);
    wait_aw();
    send_beats(int'(l) + 1, wlast_at, gap);
    get_b($urandom_range(0, 3));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[7] = '{0, 1, 2, 3, 7, 15, 5};
    ARESET = 1'b1;
    bus.AWVALID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0; bus.AWID = 0;
    bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.WLAST = 0; bus.BREADY = 0;
    repeat (3) tick();
    ARESET = 1'b0;

    // INCR and WRAP address sequences
    wr_log.delete(); b_log.delete();
    burst(32'h100, 8'd3, 3'd2, 2'b01, 4'd5, 3, 1);
    chk("t1_count", wr_log.size(), 4);
    chk("t1_a0", wr_log[0], 32'h100); chk("t1_a1", wr_log[1], 32'h104);
    chk("t1_a2", wr_log[2], 32'h108); chk("t1_a3", wr_log[3], 32'h10C);
    chk("t1_b", b_log[0], {4'd5, 2'b00});
    wr_log.delete(); b_log.delete();
    burst(32'h108, 8'd3, 3'd2, 2'b10, 4'd6, 3, 0);
    chk("t2_a0", wr_log[0], 32'h108); chk("t2_a1", wr_log[1], 32'h10C);
    chk("t2_a2", wr_log[2], 32'h100); chk("t2_a3", wr_log[3], 32'h104);
    chk("t2_b", b_log[0], {4'd6, 2'b00});

    // FIXED and wrap-around of the address space
    wr_log.delete(); b_log.delete();
    burst(32'h40, 8'd2, 3'd2, 2'b00, 4'd1, 2, 0);
    burst(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 4'd2, 1, 0);
    chk("t3_count", wr_log.size(), 5);
    chk("t3_f0", wr_log[0], 32'h40); chk("t3_f2", wr_log[2], 32'h40);
    chk("t3_i0", wr_log[3], 32'hFFFF_FFFC); chk("t3_i1", wr_log[4], 32'h0);

    // Back-pressured response with the next AW already waiting
    wr_log.delete(); b_log.delete();
    set_aw(32'h200, 8'd0, 3'd2, 2'b01, 4'd7);
    wait_aw();
    send_beats(1, 0, 0);
    set_aw(32'h300, 8'd0, 3'd2, 2'b01, 4'd9);
    bus.BREADY = 1'b0;
    repeat (5) begin
      @(negedge ACLK);
      chk("t4_awready", bus.AWREADY, 0);
      chk("t4_bvalid", bus.BVALID, 1);
      chk("t4_bid", bus.BID, 4'd7);
    end
    tick();
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    chk("t4_bvalid_hs", bus.BVALID, 1);
    tick();
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    chk("t4_aw_next", bus.AWREADY, 1);
    tick();
    bus.AWVALID = 1'b0;
    send_beats(1, 0, 0);
    get_b(0);
    chk("t4_b_count", b_log.size(), 2);
    chk("t4_b2", b_log[1], {4'd9, 2'b00});

    // Illegal bursts: consumed but never written
    wr_log.delete(); b_log.delete();
    burst(32'h0, 8'd2, 3'd3, 2'b01, 4'd1, 2, 0);
    burst(32'h0, 8'd2, 3'd2, 2'b11, 4'd2, 2, 0);
    burst(32'h8, 8'd2, 3'd2, 2'b10, 4'd3, 2, 0);
    chk("t5_no_writes", wr_log.size(), 0);
    chk("t5_b0", b_log[0], {4'd1, 2'b10});
    chk("t5_b1", b_log[1], {4'd2, 2'b10});
    chk("t5_b2", b_log[2], {4'd3, 2'b10});

    // Reset in the middle of a burst
    wr_log.delete(); b_log.delete();
    set_aw(32'h0, 8'd7, 3'd2, 2'b01, 4'd4);
    wait_aw();
    send_beats(2, 7, 0);
    bus.WVALID = 1'b1;
    #2 ARESET = 1'b1;
    tick(); tick();
    ARESET = 1'b0; bus.WVALID = 1'b0;
    chk("t6_partial", wr_log.size(), 2);
    chk("t6_no_b", b_log.size(), 0);
    burst(32'h500, 8'd1, 3'd2, 2'b01, 4'd3, 1, 0);
    chk("t6_after", b_log[0], {4'd3, 2'b00});
    burst(32'h600, 8'd3, 3'd2, 2'b01, 4'd8, 1, 0);
`ifdef AXI4_SLV_WR_WLAST_CHK_EN
    chk("t6_wlast", b_log[1], {4'd8, 2'b10});
`else
    chk("t6_wlast", b_log[1], {4'd8, 2'b00});
`endif

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] l;
      logic [2:0] s;
      int wl;
      l  = 8'(lens[$urandom_range(0, 6)]);
      s  = ($urandom_range(0, 4) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      wl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, int'(l)) : int'(l);
      if ($urandom_range(0, 3) == 0) begin
        bus.WVALID = 1'b1; bus.WDATA = $urandom;
        tick(); tick();
        bus.WVALID = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
      burst($urandom, l, s, 2'($urandom_range(0, 3)), 4'($urandom), wl, 2);
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
